jk_cmd_driver: RTL

- Upstream command stage for the JK flip-flop built on a D flip-flop.
- Accepts hold/reset/set/toggle commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered j/k levels to the downstream flip-flop for a programmable number of cycles per command.
- Keeps a shadow model of the downstream Q, cycle-accurate to the flip-flop's output.

---
 rtl/jk_cmd_driver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/jk_cmd_driver.sv
// Command FIFO + drive FSM feeding j/k to a downstream JK flip-flop, with a shadow Q model.
// Optional JK_Q_CHECK_EN adds q_in and a sticky q_mismatch flag comparing the real Q to the model.
module jk_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_cnt,
  output logic                     cmd_ready,
  output logic                     j,
  output logic                     k,
  output logic                     busy,
  output logic                     q_model,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     state_dbg
`ifdef JK_Q_CHECK_EN
  ,
  input  logic                     q_in,
  output logic                     q_mismatch
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = CNT_W + 2;

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on the registered fifo_level, never on a same-cycle pop.
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             j_d, k_d;
  logic             push, pop, fifo_empty;
  logic [EW-1:0]    head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_cnt;

  assign cmd_ready  = (fifo_level != LW'(DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign push       = cmd_valid & cmd_ready;
  assign head       = mem[rd_ptr];
  assign head_op    = head[EW-1:CNT_W];
  assign head_cnt   = head[CNT_W-1:0];
  assign busy       = (state_q == DRIVE);
  assign state_dbg  = state_q;

  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    rem_d   = rem_q;
    j_d     = j;
    k_d     = k;
    case (state_q)
      IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
          j_d     = head_op[1];
          k_d     = head_op[0];
          rem_d   = (head_cnt == '0) ? CNT_W'(1) : head_cnt;
        end
      end
      DRIVE: begin
        if (rem_q == CNT_W'(1)) begin
          // Chain straight into the next command so there is no bubble cycle.
          if (!fifo_empty) begin
            pop   = 1'b1;
            j_d   = head_op[1];
            k_d   = head_op[0];
            rem_d = (head_cnt == '0) ? CNT_W'(1) : head_cnt;
          end else begin
            state_d = IDLE;
            j_d     = 1'b0;
            k_d     = 1'b0;
            rem_d   = '0;
          end
        end else begin
          rem_d = rem_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        j_d     = 1'b0;
        k_d     = 1'b0;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_cnt};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      j       <= 1'b0;
      k       <= 1'b0;
      q_model <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      j       <= j_d;
      k       <= k_d;
      // Same JK equation the downstream flop applies to the j/k it sees this cycle.
      q_model <= (j & ~q_model) | (~k & q_model);
    end
  end

`ifdef JK_Q_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_mismatch <= 1'b0;
    else if (q_in != q_model) q_mismatch <= 1'b1;
  end
`endif

endmodule
